// File: rtl/osc_scan_scheduler.sv
// osc_scan_scheduler: raster sequencer for the oscilloscope display.
// Each line is fetched from the store with a REQ/ACK handshake, shifted out
// LSB first on osc, and followed by a flyback. The CPU clock enable is raised
// only while the display is in flyback or idle. This keeps CPU store access
// and display fetches from ever overlapping.
module osc_scan_scheduler #(
    parameter int N_OSC       = 50,
    parameter int LINE_COUNT  = 32,
    parameter int TUBES       = 2,
    parameter int FLYBACK     = 4,
    parameter int ACK_TIMEOUT = 16,
    localparam int TW = $clog2(TUBES),
    localparam int LW = $clog2(LINE_COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [TW-1:0]    tube_sel,
    output logic             line_req,
    output logic [TW+LW-1:0] line_addr,
    input  logic             line_ack,
    input  logic [N_OSC-1:0] line_data,
    output logic             osc,
    output logic             x_sync,
    output logic             y_sync,
    output logic             cpu_ce,
    output logic             err
);

    // One counter serves as the fetch timeout, the scan bit index and the
    // flyback length, so it is sized for the largest of the three.
    localparam int CMAX_A = (N_OSC > FLYBACK) ? N_OSC : FLYBACK;
    localparam int CMAX   = (CMAX_A > ACK_TIMEOUT) ? CMAX_A : ACK_TIMEOUT;
    localparam int CW     = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SCAN_LAST = CW'(N_OSC - 1);
    localparam logic [CW-1:0] FLY_LAST  = CW'(FLYBACK - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(ACK_TIMEOUT - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINE_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        SCAN    = 2'd2,
        FLYBACK_ST = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LW-1:0]      line_q, line_d;
    logic [TW-1:0]      tube_q, tube_d;
    logic [N_OSC-1:0]   shift_q, shift_d;
    logic               err_q, err_d;
    logic               req_q, req_d;
    logic [TW+LW-1:0]   addr_q, addr_d;
    logic               osc_q, osc_d;
    logic               xs_q, xs_d;
    logic               ys_q, ys_d;
    logic               ce_q, ce_d;

    // Next state plus the output values that will be visible in that state,
    // so every output comes straight from a flop.
    always_comb begin
        // NOTE: every variable gets a default before the case; a path that
        // left one unassigned would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        tube_d  = tube_q;
        shift_d = shift_q;
        err_d   = err_q;
        addr_d  = addr_q;
        req_d   = 1'b0;
        ce_d    = 1'b0;
        osc_d   = 1'b0;
        xs_d    = 1'b0;
        ys_d    = 1'b0;

        case (state_q)
            IDLE: begin
                line_d = '0;
                if (en) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                    tube_d  = tube_sel;
                    addr_d  = {tube_sel, {LW{1'b0}}};
                    req_d   = 1'b1;
                    ys_d    = 1'b1;
                end else begin
                    ce_d = 1'b1;
                end
            end

            FETCH: begin
                // ACK has priority over a timeout landing in the same cycle.
                if (line_ack || (cnt_q == TO_LAST)) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    if (line_ack) begin
                        osc_d   = line_data[0];
                        shift_d = line_data >> 1;
                    end else begin
                        shift_d = '0;
                        err_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    req_d = 1'b1;
                end
            end

            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    state_d = FLYBACK_ST;
                    cnt_d   = '0;
                    ce_d    = 1'b1;
                    xs_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    osc_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end

            FLYBACK_ST: begin
                if (cnt_q == FLY_LAST) begin
                    cnt_d = '0;
                    if (en) begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                        if (line_q == LINE_LAST) begin
                            // New frame: pick up the tube selection here only.
                            line_d = '0;
                            tube_d = tube_sel;
                            addr_d = {tube_sel, {LW{1'b0}}};
                            ys_d   = 1'b1;
                        end else begin
                            line_d = line_q + LW'(1);
                            addr_d = {tube_q, line_q + LW'(1)};
                        end
                    end else begin
                        state_d = IDLE;
                        line_d  = '0;
                        ce_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    ce_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignments in clocked logic so every flop
            // samples the pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            line_q  <= '0;
            tube_q  <= '0;
            // NOTE: the line shift register is small flop storage, not a
            // RAM, so it is reset with everything else.
            shift_q <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            osc_q   <= 1'b0;
            xs_q    <= 1'b0;
            ys_q    <= 1'b0;
            ce_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            tube_q  <= tube_d;
            shift_q <= shift_d;
            err_q   <= err_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            osc_q   <= osc_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            ce_q    <= ce_d;
        end
    end

    assign line_req  = req_q;
    assign line_addr = addr_q;
    assign osc       = osc_q;
    assign x_sync    = xs_q;
    assign y_sync    = ys_q;
    assign cpu_ce    = ce_q;
    assign err       = err_q;

    // The store is never granted to the CPU while a display fetch is pending.
    a_store_mutex: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_q && ce_q));

endmodule

// File: tb/tb_osc_scan_scheduler.sv
// Self-checking bench for osc_scan_scheduler with a small store model and an
// expected-line scoreboard.
module tb_osc_scan_scheduler;

    localparam int N_OSC       = 4;
    localparam int LINE_COUNT  = 4;
    localparam int TUBES       = 2;
    localparam int FLYBACK     = 3;
    localparam int ACK_TIMEOUT = 8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [0:0] tube_sel;
    logic       line_req;
    logic [2:0] line_addr;
    logic       line_ack;
    logic [3:0] line_data;
    logic       osc;
    logic       x_sync;
    logic       y_sync;
    logic       cpu_ce;
    logic       err;

    int n_checks;
    int n_fail;

    // Store model controls, written by the main sequence.
    int         ack_lat;
    logic [3:0] fix_data;
    bit         rand_mode;
    logic [3:0] exp_q[$];

    osc_scan_scheduler #(
        .N_OSC(N_OSC),
        .LINE_COUNT(LINE_COUNT),
        .TUBES(TUBES),
        .FLYBACK(FLYBACK),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .tube_sel(tube_sel),
        .line_req(line_req),
        .line_addr(line_addr),
        .line_ack(line_ack),
        .line_data(line_data),
        .osc(osc),
        .x_sync(x_sync),
        .y_sync(y_sync),
        .cpu_ce(cpu_ce),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Checks one full line fetched with immediate ACK, starting at its fetch
    // cycle and ending at the fetch cycle of the following line.
    task automatic run_line(input logic [2:0] exp_addr, input logic exp_y,
                            input int next_lat, input logic [3:0] next_data);
        int xs;
        int ys;
        check("line_req", line_req, 1'b1);
        check("line_addr", line_addr, exp_addr);
        check("y_sync", y_sync, exp_y);
        check("cpu_ce_fetch", cpu_ce, 1'b0);
        xs = 0;
        ys = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 0) begin
                ack_lat  = next_lat;
                fix_data = next_data;
            end
            xs += int'(x_sync);
            ys += int'(y_sync);
        end
        check("x_sync_count", xs, 1);
        check("y_sync_mid", ys, 0);
        step();
    endtask

    // Store responder plus scoreboard monitor, both acting on the negedge.
    initial begin : store_model
        logic [3:0] word;
        logic [3:0] cur;
        int lat;
        int flen;
        int exp_len;
        int k;
        bit prev_req;
        bit in_scan;
        bit timed;
        line_ack = 1'b0;
        line_data = '0;
        flen = 0;
        prev_req = 1'b0;
        in_scan = 1'b0;
        timed = 1'b0;
        exp_len = 0;
        lat = 0;
        k = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                flen = 0;
                prev_req = 1'b0;
                in_scan = 1'b0;
                exp_q.delete();
                line_ack = 1'b0;
            end else begin
                check("mutex", line_req & cpu_ce, 1'b0);
                if (prev_req && !line_req) begin
                    check("fetch_len", flen, exp_len);
                    if (timed) check("err_set", err, 1'b1);
                    if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                    else cur = exp_q.pop_front();
                    in_scan = 1'b1;
                    k = 0;
                    flen = 0;
                end
                if (in_scan) begin
                    if (k < N_OSC) begin
                        check("scan_busy", {line_req, cpu_ce}, 2'b00);
                        check("osc", osc, cur[k]);
                        k++;
                    end else begin
                        check("flyback_ce", cpu_ce, 1'b1);
                        check("flyback_xsync", x_sync, 1'b1);
                        in_scan = 1'b0;
                    end
                end
                if (line_req) begin
                    if (flen == 0) begin
                        lat  = rand_mode ? int'($urandom_range(0, 9)) : ack_lat;
                        word = rand_mode ? 4'($urandom) : fix_data;
                        timed = (lat >= ACK_TIMEOUT);
                        exp_len = timed ? ACK_TIMEOUT : lat + 1;
                        exp_q.push_back(timed ? 4'b0000 : word);
                    end
                    line_ack  = (flen == lat);
                    line_data = (flen == lat) ? word : 4'($urandom);
                    flen++;
                end else begin
                    line_ack  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
                    line_data = 4'($urandom);
                end
                prev_req = line_req;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [3:0] d;
        n_checks = 0;
        n_fail = 0;
        rand_mode = 1'b0;
        ack_lat = 0;
        fix_data = 4'b1011;
        en = 1'b0;
        tube_sel = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset and release with the display disabled.
        repeat (3) step();
        rst_n = 1'b1;
        check("reset_vals", {line_req, line_addr, osc, x_sync, y_sync, cpu_ce, err}, 9'd0);
        step();
        check("idle_ce", cpu_ce, 1'b1);
        check("idle_req", line_req, 1'b0);

        // First line of tube 1, immediate ACK, data 1011.
        tube_sel = 1'b1;
        en = 1'b1;
        fix_data = 4'b1011;
        ack_lat = 0;
        step();
        check("l0_req", line_req, 1'b1);
        check("l0_addr", line_addr, 3'b100);
        check("l0_ysync", y_sync, 1'b1);
        check("l0_ce", cpu_ce, 1'b0);
        d = 4'b1011;
        for (int i = 0; i < N_OSC; i++) begin
            step();
            check("l0_osc", osc, d[i]);
            check("l0_scan_ce", cpu_ce, 1'b0);
        end
        for (int f = 0; f < FLYBACK; f++) begin
            step();
            check("l0_fly_ce", cpu_ce, 1'b1);
            check("l0_fly_x", x_sync, (f == 0));
            check("l0_fly_osc", osc, 1'b0);
        end
        step();

        // Rest of frame 1, frame 2 with a mid-frame tube change, frame 3 start.
        run_line(3'b101, 1'b0, 0, 4'b0011);
        run_line(3'b110, 1'b0, 0, 4'b1100);
        run_line(3'b111, 1'b0, 0, 4'b1010);
        run_line(3'b100, 1'b1, 0, 4'b0101);
        tube_sel = 1'b0;
        run_line(3'b101, 1'b0, 0, 4'b1110);
        run_line(3'b110, 1'b0, 0, 4'b0111);
        run_line(3'b111, 1'b0, 0, 4'b1001);
        run_line(3'b000, 1'b1, 5, 4'b0110);

        // Line 1: ACK five cycles late.
        check("slow_addr", line_addr, 3'b001);
        for (int i = 0; i < 6; i++) begin
            check("slow_req", line_req, 1'b1);
            check("slow_ce", cpu_ce, 1'b0);
            check("slow_err", err, 1'b0);
            step();
        end
        check("slow_done", line_req, 1'b0);
        ack_lat = 99;
        d = 4'b0110;
        check("slow_osc", osc, d[0]);
        for (int i = 1; i < N_OSC; i++) begin
            step();
            check("slow_osc", osc, d[i]);
        end
        repeat (FLYBACK + 1) step();

        // Line 2: no ACK at all.
        check("to_addr", line_addr, 3'b010);
        for (int i = 0; i < ACK_TIMEOUT; i++) begin
            check("to_req", line_req, 1'b1);
            check("to_err_pending", err, 1'b0);
            step();
        end
        check("to_req_drop", line_req, 1'b0);
        check("to_err", err, 1'b1);
        ack_lat = 0;
        fix_data = 4'b1101;
        for (int i = 0; i < N_OSC; i++) begin
            check("to_osc_blank", osc, 1'b0);
            step();
        end
        repeat (FLYBACK) step();
        run_line(3'b011, 1'b0, 0, 4'b0010);

        // Frame 4: drop enable during the scan of line 2.
        run_line(3'b000, 1'b1, 0, 4'b1111);
        run_line(3'b001, 1'b0, 0, 4'b0100);
        check("drop_addr", line_addr, 3'b010);
        step();
        step();
        en = 1'b0;
        step();
        step();
        step();
        check("drop_fly_x", x_sync, 1'b1);
        check("drop_fly_ce", cpu_ce, 1'b1);
        step();
        step();
        step();
        check("drop_idle_ce", cpu_ce, 1'b1);
        check("drop_idle_req", line_req, 1'b0);
        check("drop_addr_hold", line_addr, 3'b010);
        step();
        check("idle_stay_ce", cpu_ce, 1'b1);
        check("idle_stay_req", line_req, 1'b0);
        en = 1'b1;
        step();
        check("restart_req", line_req, 1'b1);
        check("restart_addr", line_addr, 3'b000);
        check("restart_ysync", y_sync, 1'b1);

        // Asynchronous reset in the middle of a scan.
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_err", err, 1'b0);
        check("async_rst_vals", {line_req, line_addr, osc, x_sync, y_sync, cpu_ce, err}, 9'd0);
        en = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_hold_vals", {line_req, line_addr, osc, x_sync, y_sync, cpu_ce, err}, 9'd0);
        step();
        check("rst_rel_ce", cpu_ce, 1'b1);
        check("rst_rel_req", line_req, 1'b0);

        // Random ACK latency, EN and TUBE_SEL.
        rand_mode = 1'b1;
        en = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            step();
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0) tube_sel = 1'($urandom_range(0, 1));
        end
        en = 1'b0;
        repeat (40) step();
        check("sb_drained", exp_q.size(), 0);
        check("final_idle_ce", cpu_ce, 1'b1);
        check("final_idle_req", line_req, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
